// File: rtl/pulse_train_if.sv
// Trigger/ack inputs and burst status outputs of the pulse train generator.
interface pulse_train_if #(parameter int CNT_W = 4);
  logic             trig;
  logic             ack;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic             overrun;
  logic [CNT_W-1:0] pulse_idx;

  modport master (output trig, ack, input pulse_out, busy, done, overrun, pulse_idx);
  modport slave  (input trig, ack, output pulse_out, busy, done, overrun, pulse_idx);
endinterface

// File: rtl/pulse_train_gen.sv
// Emits a burst of N_PULSES pulses (HIGH_LEN high, LOW_LEN low) per trig rising edge,
// then holds done until ack; late triggers set a sticky overrun flag.
module pulse_train_gen #(
  parameter int N_PULSES = 4,
  parameter int HIGH_LEN = 3,
  parameter int LOW_LEN  = 2,
  parameter int CNT_W    = 4
) (
  input  logic          clk,
  input  logic          rst,
  pulse_train_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(HIGH_LEN - 1);
  localparam logic [CNT_W-1:0] LO_LAST  = CNT_W'(LOW_LEN - 1);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(N_PULSES - 1);

  state_t           state, state_n;
  logic             trig_q;
  logic [CNT_W-1:0] phase, phase_n;
  logic [CNT_W-1:0] idx, idx_n;
  logic             ovr, ovr_n;
  logic             rise;

  assign rise = bus.trig & ~trig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      trig_q        <= 1'b0;
      phase         <= '0;
      idx           <= '0;
      ovr           <= 1'b0;
      bus.pulse_out <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= state_n;
      trig_q        <= bus.trig;
      phase         <= phase_n;
      idx           <= idx_n;
      ovr           <= ovr_n;
      // outputs are registered decodes of the next state
      bus.pulse_out <= (state_n == HIGH);
      bus.busy      <= (state_n == HIGH) || (state_n == LOW);
      bus.done      <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    idx_n   = idx;
    ovr_n   = ovr;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n = HIGH;
          phase_n = '0;
          idx_n   = '0;
        end
      end
      HIGH: begin
        if (rise) ovr_n = 1'b1;
        if (phase == HI_LAST) begin
          phase_n = '0;
          state_n = (idx == IDX_LAST) ? DONE : LOW;
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      LOW: begin
        if (rise) ovr_n = 1'b1;
        if (phase == LO_LAST) begin
          phase_n = '0;
          idx_n   = idx + 1'b1;
          state_n = HIGH;
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      DONE: begin
        if (bus.ack) begin
          state_n = IDLE;
          ovr_n   = 1'b0;
        end
        // a coincident trigger edge keeps overrun set
        if (rise) ovr_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.overrun   = ovr;
  assign bus.pulse_idx = idx;
endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench: a burst-position model predicts each cycle's outputs for two configurations.
module tb_pulse_train_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pulse_train_if #(.CNT_W(4)) bus0 ();
  pulse_train_if #(.CNT_W(4)) bus1 ();

  pulse_train_gen #(.N_PULSES(4), .HIGH_LEN(3), .LOW_LEN(2), .CNT_W(4))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pulse_train_gen #(.N_PULSES(1), .HIGH_LEN(1), .LOW_LEN(1), .CNT_W(4))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    bit act, dn, ovr, tq;
    int pos, idx;
  } mst_t;

  typedef struct {
    int po, busy, done, ovr, idx;
  } exp_t;

  mst_t m0, m1;
  exp_t q0[$], q1[$];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic mst_t step(input mst_t s, input bit r, input bit t, input bit a,
                                input int np, input int h, input int l);
    mst_t n = s;
    bit rise;
    int total = np*h + (np-1)*l;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    rise = t & ~s.tq;
    n.tq = t;
    if (s.act) begin
      if (rise) n.ovr = 1;
      n.pos = s.pos + 1;
      if (n.pos == total) begin
        n.act = 0; n.dn = 1; n.idx = np - 1;
      end
    end else if (s.dn) begin
      if (a) begin n.dn = 0; n.ovr = 0; end
      if (rise) n.ovr = 1;
    end else if (rise) begin
      n.act = 1; n.pos = 0;
    end
    return n;
  endfunction

  function automatic exp_t outs(input mst_t s, input int h, input int l);
    exp_t e;
    e.po   = (s.act && (s.pos % (h+l)) < h) ? 1 : 0;
    e.busy = s.act ? 1 : 0;
    e.done = s.dn ? 1 : 0;
    e.ovr  = s.ovr ? 1 : 0;
    e.idx  = s.act ? s.pos / (h+l) : s.idx;
    return e;
  endfunction

  task automatic cyc(input bit r, input bit t, input bit a);
    exp_t e;
    rst = r;
    bus0.trig = t; bus0.ack = a;
    bus1.trig = t; bus1.ack = a;
    m0 = step(m0, r, t, a, 4, 3, 2);
    m1 = step(m1, r, t, a, 1, 1, 1);
    q0.push_back(outs(m0, 3, 2));
    q1.push_back(outs(m1, 1, 1));
    @(posedge clk);
    #1;
    e = q0.pop_front();
    chk("d0.pulse_out", int'(bus0.pulse_out), e.po);
    chk("d0.busy",      int'(bus0.busy),      e.busy);
    chk("d0.done",      int'(bus0.done),      e.done);
    chk("d0.overrun",   int'(bus0.overrun),   e.ovr);
    chk("d0.pulse_idx", int'(bus0.pulse_idx), e.idx);
    e = q1.pop_front();
    chk("d1.pulse_out", int'(bus1.pulse_out), e.po);
    chk("d1.busy",      int'(bus1.busy),      e.busy);
    chk("d1.done",      int'(bus1.done),      e.done);
    chk("d1.overrun",   int'(bus1.overrun),   e.ovr);
    chk("d1.pulse_idx", int'(bus1.pulse_idx), e.idx);
  endtask

  task automatic run(input int n, input bit r, input bit t, input bit a);
    for (int i = 0; i < n; i++) cyc(r, t, a);
  endtask

  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    rst = 1'b1;
    bus0.trig = 1'b0; bus0.ack = 1'b0;
    bus1.trig = 1'b0; bus1.ack = 1'b0;
    @(negedge clk);

    run(2, 1, 0, 0);          // reset state
    run(3, 0, 0, 0);
    run(4, 0, 1, 0);          // burst 1 starts, trig held
    run(3, 0, 1, 1);          // ack while busy is ignored
    run(16, 0, 1, 0);         // finish burst, trig held past done: no overrun
    run(1, 0, 1, 1);          // ack in DONE
    run(2, 0, 0, 0);
    run(7, 0, 1, 0);          // burst 2, into 2nd pulse
    run(1, 0, 0, 0);
    run(14, 0, 1, 0);         // re-rise during burst -> overrun
    run(1, 0, 0, 0);
    run(1, 0, 1, 1);          // ack + rise in DONE: IDLE, overrun stays set
    run(3, 0, 1, 0);          // held trig does not retrigger
    run(1, 0, 0, 0);
    run(12, 0, 1, 0);         // burst 3 into 3rd pulse
    run(2, 1, 1, 0);          // mid-burst reset with trig high
    run(22, 0, 1, 0);         // trig high at release starts a new burst
    run(1, 0, 1, 1);
    run(3, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
